// File: rtl/cache_bram_v3.sv
// True-dual-port line store for the unified cache: per-lane write masks, read-valid pulses,
// optional output register, and a post-reset zeroing sweep instead of a power-on initialiser.
module cache_bram_v3 #(
    parameter int WIDTH          = 147,
    parameter int ADDR_W         = 10,
    parameter int LANES          = 1,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_busy,
    input  logic              data_re,
    input  logic              data_we,
    input  logic [LANES-1:0]  data_wmask,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic              data_valid,
    input  logic              inst_re,
    input  logic              inst_we,
    input  logic [LANES-1:0]  inst_wmask,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [WIDTH-1:0]  inst_in,
    output logic [WIDTH-1:0]  inst_out,
    output logic              inst_valid
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int LANE_W = (WIDTH + LANES - 1) / LANES;

    typedef enum logic [1:0] {RESET, CLEAR, READY} state_t;

    state_t            state, state_next;
    logic              sweep;
    logic [ADDR_W-1:0] clr_cnt;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              data_rd, data_wr, inst_rd, inst_wr, same_addr;
    logic [WIDTH-1:0]  data_bmask, inst_bmask, inst_keep, data_add;
    logic [WIDTH-1:0]  data_word, inst_word;
    logic [WIDTH-1:0]  data_s1, inst_s1;
    logic              data_s1_v, inst_s1_v;

    // The cycle leaving RESET already clears entry 0, so the sweep spans exactly DEPTH cycles.
    always_comb begin
        state_next = state;
        sweep      = 1'b0;
        case (state)
            RESET: begin
                sweep      = (CLEAR_ON_RESET != 0) && !rst;
                state_next = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            end
            CLEAR: begin
                sweep = !rst;
                if (clr_cnt == {ADDR_W{1'b1}})
                    state_next = READY;
            end
            READY:   state_next = READY;
            default: state_next = RESET;
        endcase
    end

    assign init_busy = rst || (state != READY);
    assign data_rd   = data_re && !init_busy;
    assign data_wr   = data_we && !init_busy;
    assign inst_rd   = inst_re && !init_busy;
    assign inst_wr   = inst_we && !init_busy;
    assign same_addr = (data_addr == inst_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RESET;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (sweep)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        data_bmask = '0;
        inst_bmask = '0;
        for (int b = 0; b < WIDTH; b++) begin
            data_bmask[b] = |(data_wmask & (LANES'(1) << (b / LANE_W)));
            inst_bmask[b] = |(inst_wmask & (LANES'(1) << (b / LANE_W)));
        end
    end

    // On a same-address double write both ports store the identical merged word:
    // data lanes win where data_wmask is set, inst lanes fill the rest.
    always_comb begin
        inst_keep = (data_wr && same_addr) ? data_bmask : '0;
        data_add  = (inst_wr && same_addr) ? (inst_bmask & ~data_bmask) : '0;
        inst_word = (mem[inst_addr] & ~(inst_bmask | inst_keep))
                  | (inst_in & inst_bmask & ~inst_keep)
                  | (data_in & inst_keep);
        data_word = (mem[data_addr] & ~(data_bmask | data_add))
                  | (data_in & data_bmask)
                  | (inst_in & data_add);
    end

    always_ff @(posedge clk) begin
        if (sweep)
            mem[clr_cnt] <= '0;
        if (data_wr)
            mem[data_addr] <= data_word;
        if (inst_wr)
            mem[inst_addr] <= inst_word;
    end

    // First read stage samples pre-edge contents, giving read-first behaviour on both ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_s1   <= '0;
            inst_s1   <= '0;
            data_s1_v <= 1'b0;
            inst_s1_v <= 1'b0;
        end else begin
            data_s1_v <= data_rd;
            inst_s1_v <= inst_rd;
            if (data_rd)
                data_s1 <= mem[data_addr];
            if (inst_rd)
                inst_s1 <= mem[inst_addr];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] data_s2, inst_s2;
            logic             data_s2_v, inst_s2_v;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_s2   <= '0;
                    inst_s2   <= '0;
                    data_s2_v <= 1'b0;
                    inst_s2_v <= 1'b0;
                end else begin
                    data_s2_v <= data_s1_v;
                    inst_s2_v <= inst_s1_v;
                    if (data_s1_v)
                        data_s2 <= data_s1;
                    if (inst_s1_v)
                        inst_s2 <= inst_s1;
                end
            end

            assign data_out   = data_s2;
            assign data_valid = data_s2_v;
            assign inst_out   = inst_s2;
            assign inst_valid = inst_s2_v;
        end else begin : g_no_out_reg
            assign data_out   = data_s1;
            assign data_valid = data_s1_v;
            assign inst_out   = inst_s1;
            assign inst_valid = inst_s1_v;
        end
    endgenerate
endmodule

// File: tb/tb_cache_bram_v3.sv
// Directed bench: instance A (147 bits, 3 lanes, no output reg), instance B (16 bits, 2 lanes, output reg).
module tb_cache_bram_v3;
    localparam logic [146:0] ONES  = {147{1'b1}};
    localparam logic [146:0] LANE0 = {98'b0, {49{1'b1}}};
    localparam logic [146:0] LANE1 = {49'b0, {49{1'b1}}, 49'b0};
    localparam logic [146:0] LANE2 = {{49{1'b1}}, 98'b0};
    localparam logic [146:0] MID0  = LANE0 | LANE2;
    localparam logic [146:0] PAT   = {19'h5_1234, 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C};
    localparam logic [146:0] COL   = LANE0 | (PAT & (LANE1 | LANE2));
    localparam logic [146:0] FILL  = 147'({19{8'h5A}});

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // instance A
    logic         a_rst, a_busy;
    logic         a_data_re, a_data_we, a_data_valid, a_inst_re, a_inst_we, a_inst_valid;
    logic [2:0]   a_data_wmask, a_inst_wmask;
    logic [3:0]   a_data_addr, a_inst_addr;
    logic [146:0] a_data_in, a_data_out, a_inst_in, a_inst_out;

    cache_bram_v3 #(.WIDTH(147), .ADDR_W(4), .LANES(3), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .rst(a_rst), .init_busy(a_busy),
        .data_re(a_data_re), .data_we(a_data_we), .data_wmask(a_data_wmask),
        .data_addr(a_data_addr), .data_in(a_data_in), .data_out(a_data_out), .data_valid(a_data_valid),
        .inst_re(a_inst_re), .inst_we(a_inst_we), .inst_wmask(a_inst_wmask),
        .inst_addr(a_inst_addr), .inst_in(a_inst_in), .inst_out(a_inst_out), .inst_valid(a_inst_valid)
    );

    // instance B
    logic        b_rst, b_busy;
    logic        b_data_re, b_data_we, b_data_valid, b_inst_re, b_inst_we, b_inst_valid;
    logic [1:0]  b_data_wmask, b_inst_wmask;
    logic [3:0]  b_data_addr, b_inst_addr;
    logic [15:0] b_data_in, b_data_out, b_inst_in, b_inst_out;

    cache_bram_v3 #(.WIDTH(16), .ADDR_W(4), .LANES(2), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .rst(b_rst), .init_busy(b_busy),
        .data_re(b_data_re), .data_we(b_data_we), .data_wmask(b_data_wmask),
        .data_addr(b_data_addr), .data_in(b_data_in), .data_out(b_data_out), .data_valid(b_data_valid),
        .inst_re(b_inst_re), .inst_we(b_inst_we), .inst_wmask(b_inst_wmask),
        .inst_addr(b_inst_addr), .inst_in(b_inst_in), .inst_out(b_inst_out), .inst_valid(b_inst_valid)
    );

    typedef struct {
        logic         d_re, d_we;
        logic [2:0]   d_mask;
        logic [3:0]   d_addr;
        logic [146:0] d_in;
        logic         i_re, i_we;
        logic [2:0]   i_mask;
        logic [3:0]   i_addr;
        logic [146:0] i_in;
        logic         e_dv;
        logic [146:0] e_dout;
        logic         e_iv;
        logic [146:0] e_iout;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic d_re, input logic d_we, input logic [2:0] d_mask,
                                input logic [3:0] d_addr, input logic [146:0] d_in,
                                input logic i_re, input logic i_we, input logic [2:0] i_mask,
                                input logic [3:0] i_addr, input logic [146:0] i_in,
                                input logic e_dv, input logic [146:0] e_dout,
                                input logic e_iv, input logic [146:0] e_iout);
        vec_t v;
        v.d_re = d_re; v.d_we = d_we; v.d_mask = d_mask; v.d_addr = d_addr; v.d_in = d_in;
        v.i_re = i_re; v.i_we = i_we; v.i_mask = i_mask; v.i_addr = i_addr; v.i_in = i_in;
        v.e_dv = e_dv; v.e_dout = e_dout; v.e_iv = e_iv; v.e_iout = e_iout;
        return v;
    endfunction

    task automatic check(input string name, input logic [146:0] act, input logic [146:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_data_re = 0; a_data_we = 0; a_data_wmask = '0; a_data_addr = '0; a_data_in = '0;
        a_inst_re = 0; a_inst_we = 0; a_inst_wmask = '0; a_inst_addr = '0; a_inst_in = '0;
    endtask

    task automatic idle_b();
        b_data_re = 0; b_data_we = 0; b_data_wmask = '0; b_data_addr = '0; b_data_in = '0;
        b_inst_re = 0; b_inst_we = 0; b_inst_wmask = '0; b_inst_addr = '0; b_inst_in = '0;
    endtask

    task automatic write_a(input logic [3:0] addr, input logic [146:0] val);
        a_data_we = 1; a_data_wmask = 3'b111; a_data_addr = addr; a_data_in = val;
        tick();
        a_data_we = 0; a_data_wmask = '0;
    endtask

    task automatic read_a(input logic [3:0] addr, output logic [146:0] val, output logic vld);
        a_data_re = 1; a_data_addr = addr;
        tick();
        val = a_data_out;
        vld = a_data_valid;
        a_data_re = 0;
    endtask

    // Counts cycles from now until init_busy drops on A; also notes any valid seen.
    task automatic busy_len_a(output int n, output logic saw_valid);
        n = 0;
        saw_valid = 0;
        while (a_busy && n < 40) begin
            if (n == 8) begin
                a_data_we = 1; a_data_wmask = 3'b111; a_data_addr = 4'd2; a_data_in = ONES;
                a_data_re = 1;
            end else begin
                a_data_we = 0; a_data_wmask = '0; a_data_re = 0;
            end
            tick();
            saw_valid |= a_data_valid | a_inst_valid;
            n++;
        end
        a_data_we = 0; a_data_wmask = '0; a_data_re = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic saw;
        logic [146:0] rd;
        logic vld;

        idle_a();
        idle_b();
        a_rst = 1;
        b_rst = 1;
        #1;

        // Reset state, then rst mid-sweep at counter 6 and a write during busy
        repeat (3) tick();
        check("a_reset_busy", 147'(a_busy), 147'(1));
        check("a_reset_dvalid", 147'(a_data_valid), 147'(0));
        check("a_reset_dout", a_data_out, '0);
        check("a_reset_ivalid", 147'(a_inst_valid), 147'(0));
        check("a_reset_iout", a_inst_out, '0);
        a_rst = 0;
        repeat (6) tick();
        check("a_busy_mid_sweep", 147'(a_busy), 147'(1));
        a_rst = 1;
        tick();
        a_rst = 0;
        busy_len_a(n, saw);
        check("a_restart_busy_len", 147'(n), 147'(16));
        check("a_no_valid_while_busy", 147'(saw), 147'(0));
        read_a(4'd2, rd, vld);
        check("a_busy_write_dropped", rd, '0);
        check("a_read_valid", 147'(vld), 147'(1));

        // Fill with 0x5A.., reset 3 cycles, sweep must zero everything
        for (int i = 0; i < 16; i++) write_a(4'(i), FILL);
        read_a(4'd11, rd, vld);
        check("a_fill_readback", rd, FILL);
        a_rst = 1;
        repeat (3) tick();
        a_rst = 0;
        n = 0;
        while (a_busy && n < 40) begin
            tick();
            n++;
        end
        check("a_clear_busy_len", 147'(n), 147'(16));
        for (int i = 0; i < 16; i++) begin
            read_a(4'(i), rd, vld);
            check($sformatf("a_cleared_%0d", i), rd, '0);
        end

        // Table: masks, read-first, cross-port, collision, no-op write
        vecs[0]  = mk(0, 1, 3'b111, 4'd1, ONES, 0, 0, 3'b000, 4'd0, '0,  0, '0,   0, '0);
        vecs[1]  = mk(1, 0, 3'b000, 4'd1, '0,   1, 0, 3'b000, 4'd1, '0,  1, ONES, 1, ONES);
        vecs[2]  = mk(1, 1, 3'b010, 4'd1, '0,   0, 0, 3'b000, 4'd0, '0,  1, ONES, 0, ONES);
        vecs[3]  = mk(1, 0, 3'b000, 4'd1, '0,   1, 0, 3'b000, 4'd1, '0,  1, MID0, 1, MID0);
        vecs[4]  = mk(1, 0, 3'b000, 4'd2, '0,   0, 1, 3'b111, 4'd2, PAT, 1, '0,   0, MID0);
        vecs[5]  = mk(1, 0, 3'b000, 4'd2, '0,   1, 0, 3'b000, 4'd2, '0,  1, PAT,  1, PAT);
        vecs[6]  = mk(0, 1, 3'b001, 4'd5, ONES, 0, 1, 3'b111, 4'd5, PAT, 0, PAT,  0, PAT);
        vecs[7]  = mk(1, 0, 3'b000, 4'd5, '0,   1, 0, 3'b000, 4'd5, '0,  1, COL,  1, COL);
        vecs[8]  = mk(0, 1, 3'b000, 4'd5, '0,   1, 0, 3'b000, 4'd5, '0,  0, COL,  1, COL);
        vecs[9]  = mk(1, 0, 3'b000, 4'd5, '0,   0, 0, 3'b000, 4'd0, '0,  1, COL,  0, COL);
        vecs[10] = mk(0, 0, 3'b000, 4'd0, '0,   1, 1, 3'b100, 4'd3, ONES, 0, COL, 1, '0);
        vecs[11] = mk(1, 0, 3'b000, 4'd3, '0,   1, 0, 3'b000, 4'd3, '0,  1, LANE2, 1, LANE2);
        vecs[12] = mk(1, 0, 3'b000, 4'd9, '0,   0, 0, 3'b000, 4'd0, '0,  1, '0,   0, LANE2);
        for (int k = 0; k < 13; k++) begin
            a_data_re = vecs[k].d_re; a_data_we = vecs[k].d_we; a_data_wmask = vecs[k].d_mask;
            a_data_addr = vecs[k].d_addr; a_data_in = vecs[k].d_in;
            a_inst_re = vecs[k].i_re; a_inst_we = vecs[k].i_we; a_inst_wmask = vecs[k].i_mask;
            a_inst_addr = vecs[k].i_addr; a_inst_in = vecs[k].i_in;
            tick();
            check($sformatf("vec%0d_dvalid", k), 147'(a_data_valid), 147'(vecs[k].e_dv));
            check($sformatf("vec%0d_dout", k), a_data_out, vecs[k].e_dout);
            check($sformatf("vec%0d_ivalid", k), 147'(a_inst_valid), 147'(vecs[k].e_iv));
            check($sformatf("vec%0d_iout", k), a_inst_out, vecs[k].e_iout);
        end
        idle_a();

        // Instance B: latency 2, pulse width, 2-lane collision, back-to-back reads
        repeat (2) tick();
        b_rst = 0;
        n = 0;
        while (b_busy && n < 40) begin
            tick();
            n++;
        end
        check("b_clear_busy_len", 147'(n), 147'(16));
        b_data_we = 1; b_data_wmask = 2'b11; b_data_addr = 4'd7; b_data_in = 16'h1234;
        tick();
        b_data_we = 0;
        b_data_re = 1; b_inst_re = 1; b_inst_addr = 4'd7;
        tick();
        b_data_re = 0; b_inst_re = 0;
        check("b_lat_edge1_dvalid", 147'(b_data_valid), 147'(0));
        tick();
        check("b_lat_edge2_dvalid", 147'(b_data_valid), 147'(1));
        check("b_lat_dout", 147'(b_data_out), 147'(16'h1234));
        check("b_lat_ivalid", 147'(b_inst_valid), 147'(1));
        check("b_lat_iout", 147'(b_inst_out), 147'(16'h1234));
        tick();
        check("b_valid_pulse", 147'(b_data_valid), 147'(0));
        check("b_dout_hold", 147'(b_data_out), 147'(16'h1234));

        b_data_we = 1; b_data_wmask = 2'b01; b_data_addr = 4'd5; b_data_in = 16'hAAAA;
        b_inst_we = 1; b_inst_wmask = 2'b11; b_inst_addr = 4'd5; b_inst_in = 16'h5555;
        tick();
        b_data_we = 0; b_inst_we = 0;
        b_data_re = 1; b_data_addr = 4'd5;
        tick();
        b_data_addr = 4'd7;
        tick();
        b_data_re = 0;
        check("b_collision_valid", 147'(b_data_valid), 147'(1));
        check("b_collision_data", 147'(b_data_out), 147'(16'h55AA));
        tick();
        check("b_b2b_valid", 147'(b_data_valid), 147'(1));
        check("b_b2b_data", 147'(b_data_out), 147'(16'h1234));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
